// File: rtl/register_bank_mp.sv
// Multi-ported register bank with per-register busy (reservation) bits and a busy counter.
// Optional macro REGBANK_BYPASS_EN forwards same-cycle write data to the read ports.
module register_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              rb_en,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_wr;
    logic              w_rs;
    logic              w_inc;
    logic              w_dec;
    logic [DATA_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_mem_b;

    // Address 0 is not writable/reservable when hardwired; reset suppresses both.
    assign w_wr = rst && we  && !((ZERO_REG != 0) && (waddr == '0));
    assign w_rs = rst && rsv && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Counter moves with the population: a new reservation adds one, a write that
    // retires a reservation removes one unless the same edge re-reserves it.
    assign w_inc = w_rs && !r_busy[rsv_addr];
    assign w_dec = w_wr && r_busy[waddr] && !(w_rs && (rsv_addr == waddr));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) w_busy_nxt[waddr] = 1'b0;
        if (w_rs) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem      <= '{default: '0};
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr) r_mem[waddr] <= wdata;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= r_busy_cnt + (ADDR_W + 1)'(w_inc) - (ADDR_W + 1)'(w_dec);
        end
    end

    assign w_mem_a = ((ZERO_REG != 0) && (raddr_a == '0)) ? '0 : r_mem[raddr_a];
    assign w_mem_b = ((ZERO_REG != 0) && (raddr_b == '0)) ? '0 : r_mem[raddr_b];

    always_comb begin
        rdata_a = w_mem_a;
        busy_a  = r_busy[raddr_a];
        rdata_b = '0;
        busy_b  = 1'b0;
        if (rb_en) begin
            rdata_b = w_mem_b;
            busy_b  = r_busy[raddr_b];
        end
`ifdef REGBANK_BYPASS_EN
        // Forwarded reads see the post-edge busy state: cleared, unless re-reserved.
        if (w_wr && (waddr == raddr_a)) begin
            rdata_a = wdata;
            busy_a  = w_rs && (rsv_addr == raddr_a);
        end
        if (rb_en && w_wr && (waddr == raddr_b)) begin
            rdata_b = wdata;
            busy_b  = w_rs && (rsv_addr == raddr_b);
        end
`endif
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_register_bank_mp.sv
// Self-checking bench for register_bank_mp: randomized traffic against an array-based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_register_bank_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ZR = 1;
    localparam int N  = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [DW-1:0] rdata_a;
    logic [AW-1:0] raddr_b;
    logic          rb_en;
    logic [DW-1:0] rdata_b;
    logic          rsv;
    logic [AW-1:0] rsv_addr;
    logic          busy_a;
    logic          busy_b;
    logic [AW:0]   busy_cnt;

    register_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rb_en(rb_en),
        .rdata_b(rdata_b), .rsv(rsv), .rsv_addr(rsv_addr), .busy_a(busy_a),
        .busy_b(busy_b), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_mem  [N];
    logic          m_busy [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_mem[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (we && !(ZR != 0 && waddr == 0)) begin
                m_mem[waddr]  <= wdata;
                m_busy[waddr] <= 1'b0;
            end
            if (rsv && !(ZR != 0 && rsv_addr == 0))
                m_busy[rsv_addr] <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (ZR != 0 && a == 0) ? '0 : m_mem[a];
`ifdef REGBANK_BYPASS_EN
        if (rst && we && waddr == a && !(ZR != 0 && a == 0)) v = wdata;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic v;
        v = m_busy[a];
`ifdef REGBANK_BYPASS_EN
        if (rst && we && waddr == a && !(ZR != 0 && a == 0))
            v = rsv && rsv_addr == a;
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int pop;
            pop = 0;
            for (int i = 0; i < N; i++) pop += int'(m_busy[i]);
            chk("rdata_a", rdata_a, exp_data(raddr_a));
            chk("rdata_b", rdata_b, rb_en ? exp_data(raddr_b) : '0);
            chk("busy_a", 32'(busy_a), 32'(exp_busy(raddr_a)));
            chk("busy_b", 32'(busy_b), rb_en ? 32'(exp_busy(raddr_b)) : 32'd0);
            chk("busy_cnt", 32'(busy_cnt), 32'(pop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        rb_en = 1'b0; rsv = 1'b0; rsv_addr = '0;
        tick();
        chk_en = 1'b1;
        rst = 1'b1; raddr_a = 5; raddr_b = 5; rb_en = 1'b1;
        #2;
        chk("reset rdata_a", rdata_a, 32'd0);
        chk("reset rdata_b", rdata_b, 32'd0);
        chk("reset busy_cnt", 32'(busy_cnt), 32'd0);

        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 39) != 0);
            we       = ($urandom_range(0, 2) == 0);
            waddr    = AW'($urandom);
            wdata    = $urandom;
            rsv      = ($urandom_range(0, 1) == 0);
            rsv_addr = AW'($urandom);
            raddr_a  = AW'($urandom);
            raddr_b  = AW'($urandom);
            rb_en    = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset after random writes; reset must beat a same-edge write and reserve.
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            we = 1'b1; waddr = AW'($urandom); wdata = $urandom;
            rsv = 1'b1; rsv_addr = AW'($urandom);
            tick();
        end
        rst = 1'b0; we = 1'b1; waddr = 6; wdata = 32'hFFFF_0000; rsv = 1'b1; rsv_addr = 6;
        tick();
        rst = 1'b1; idle(); rb_en = 1'b1;
        for (int a = 0; a < N; a++) begin
            raddr_a = AW'(a); raddr_b = AW'(a);
            #1;
            chk("post-reset rdata_a", rdata_a, 32'd0);
            chk("post-reset rdata_b", rdata_b, 32'd0);
            chk("post-reset busy_a", 32'(busy_a), 32'd0);
        end
        chk("post-reset busy_cnt", 32'(busy_cnt), 32'd0);

        we = 1'b1; waddr = 5; wdata = 32'hDEAD_BEEF;
        tick();
        idle(); raddr_a = 5; raddr_b = 5; rb_en = 1'b0;
        #2;
        chk("r5 rdata_a", rdata_a, 32'hDEAD_BEEF);
        chk("r5 rdata_b rb_en=0", rdata_b, 32'd0);
        rb_en = 1'b1;
        #1;
        chk("r5 rdata_b rb_en=1", rdata_b, 32'hDEAD_BEEF);

        we = 1'b1; waddr = 0; wdata = 32'h1234; rsv = 1'b1; rsv_addr = 0;
        tick();
        idle(); raddr_a = 0;
        #2;
        chk("r0 rdata_a", rdata_a, 32'd0);
        chk("r0 busy_a", 32'(busy_a), 32'd0);
        chk("r0 busy_cnt", 32'(busy_cnt), 32'd0);

        rsv = 1'b1; rsv_addr = 3;
        tick();
        idle();
        #2 chk("rsv r3 busy_cnt", 32'(busy_cnt), 32'd1);
        rsv = 1'b1; rsv_addr = 7;
        tick();
        idle();
        #2 chk("rsv r7 busy_cnt", 32'(busy_cnt), 32'd2);
        we = 1'b1; waddr = 3; wdata = 32'h33;
        tick();
        idle(); raddr_a = 3; raddr_b = 7; rb_en = 1'b1;
        #2;
        chk("wr r3 busy_cnt", 32'(busy_cnt), 32'd1);
        chk("wr r3 busy_a", 32'(busy_a), 32'd0);
        chk("r7 busy_b", 32'(busy_b), 32'd1);
        rb_en = 1'b0;
        #1 chk("r7 busy_b rb_en=0", 32'(busy_b), 32'd0);

        we = 1'b1; waddr = 9; wdata = 32'hA5; rsv = 1'b1; rsv_addr = 9;
        tick();
        idle(); raddr_a = 9; raddr_b = 9; rb_en = 1'b1;
        #2;
        chk("r9 rdata_a", rdata_a, 32'hA5);
        chk("r9 busy_a", 32'(busy_a), 32'd1);
        chk("r9 busy_cnt", 32'(busy_cnt), 32'd2);
        rsv = 1'b1; rsv_addr = 9;
        tick();
        idle();
        #2 chk("re-rsv r9 busy_cnt", 32'(busy_cnt), 32'd2);

        we = 1'b1; waddr = 4; wdata = 32'h11;
        tick();
        we = 1'b1; waddr = 4; wdata = 32'h55; raddr_a = 4;
        #2;
`ifdef REGBANK_BYPASS_EN
        chk("r4 same-cycle rdata_a", rdata_a, 32'h55);
`else
        chk("r4 same-cycle rdata_a", rdata_a, 32'h11);
`endif
        chk("r4 same-cycle busy_a", 32'(busy_a), 32'd0);
        tick();
        idle();
        #2;
        chk("r4 next rdata_a", rdata_a, 32'h55);
        chk("r4 busy_cnt", 32'(busy_cnt), 32'd2);

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
